// File: rtl/snn_pkg.sv
// Shared definitions for the SNN frame sequencer slice.
// Holds the default frame geometry, the sequencer state type and the
// error codes reported on oERROR.
package snn_pkg;

  localparam int CHUNK_W     = 30;
  localparam int NUM_CHUNKS  = 27;
  localparam int IMG_W       = CHUNK_W * NUM_CHUNKS;
  localparam int RESULT_W    = 1;
  localparam int TIMEOUT_CYC = 2**20;
  localparam int IDX_W       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } seqState_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A rise on 'level' that is first sampled at edge t produces a one-cycle
// 'rise' pulse that is visible after edge t+2 and consumed at edge t+3.
// Ports:
//   wCLK120 - system clock
//   resetN  - synchronous active-low reset, clears every flop
//   level   - asynchronous level input
//   rise    - one-cycle pulse per rising edge of 'level'
module sync_edge_detect (
  input  logic wCLK120,
  input  logic resetN,
  input  logic level,
  output logic rise
);

  logic [1:0] syncQ;
  logic       prevQ;

  // Two synchroniser stages, then the previous synchronised value so the
  // rising transition can be registered as a clean single-cycle pulse.
  always_ff @(posedge wCLK120) begin
    if (!resetN) begin
      syncQ <= 2'b00;
      prevQ <= 1'b0;
      rise  <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], level};
      prevQ <= syncQ[1];
      rise  <= syncQ[1] & ~prevQ;
    end
  end

endmodule

// File: rtl/snn_frame_sequencer.sv
// Moves one input frame from the JTAG mailbox into the SNN core.
// Chunks arriving on iDATA (one per iPROGRESS rise) are assembled into
// oIMAGE; an iFINISH rise after a full frame starts the core, and the core
// result is latched and reported with a valid flag and a sticky error code.
// Ports:
//   iCLK          - 120 MHz system clock (wCLK120)
//   iRESETn       - synchronous active-low reset
//   iDATA         - chunk payload
//   iPROGRESS     - level, each rise delivers one chunk
//   iFINISH       - level, rise marks end of frame
//   oIMAGE        - assembled frame, chunk k at [k*CHUNK_W +: CHUNK_W]
//   oSNN_START    - one-cycle core start pulse
//   iSNN_DONE     - core completion pulse, iSNN_RESULT valid with it
//   iSNN_RESULT   - core result
//   oRESULT       - latched core result
//   oRESULT_VALID - result valid until the next frame begins
//   oBUSY         - high while loading, starting or running
//   oCHUNK_IDX    - chunks received in the current frame
//   oERROR        - 0 ok, 1 short frame, 2 overrun, 3 timeout (sticky)
module snn_frame_sequencer #(
  parameter int CHUNK_W     = snn_pkg::CHUNK_W,
  parameter int NUM_CHUNKS  = snn_pkg::NUM_CHUNKS,
  parameter int RESULT_W    = snn_pkg::RESULT_W,
  parameter int TIMEOUT_CYC = snn_pkg::TIMEOUT_CYC
) (
  input  logic                          iCLK,
  input  logic                          iRESETn,
  input  logic [CHUNK_W-1:0]            iDATA,
  input  logic                          iPROGRESS,
  input  logic                          iFINISH,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] oIMAGE,
  output logic                          oSNN_START,
  input  logic                          iSNN_DONE,
  input  logic [RESULT_W-1:0]           iSNN_RESULT,
  output logic [RESULT_W-1:0]           oRESULT,
  output logic                          oRESULT_VALID,
  output logic                          oBUSY,
  output logic [snn_pkg::IDX_W-1:0]     oCHUNK_IDX,
  output logic [1:0]                    oERROR
);

  import snn_pkg::*;

  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]   FULL_IDX   = IDX_W'(NUM_CHUNKS);

  seqState_e          state;
  seqState_e          nextState;
  logic               progRise;
  logic               finRise;
  logic [IDX_W-1:0]   idxQ;
  logic [TIMER_W-1:0] timerQ;

  logic               capture;
  logic [IDX_W-1:0]   writeSlot;
  logic [IDX_W-1:0]   effIdx;
  logic               startFrame;
  logic               incIdx;
  logic               clearIdx;
  logic               setErr;
  logic [1:0]         errVal;
  logic               loadResult;
  logic               clearTimer;
  logic               runTick;

  sync_edge_detect progSync (
    .wCLK120 (iCLK),
    .resetN  (iRESETn),
    .level   (iPROGRESS),
    .rise    (progRise)
  );

  sync_edge_detect finSync (
    .wCLK120 (iCLK),
    .resetN  (iRESETn),
    .level   (iFINISH),
    .rise    (finRise)
  );

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and datapath control. In LOAD a chunk arriving together with
  // FINISH is written first, so the completeness test uses the bumped index.
  // In RUN a timeout overrides an overrun flagged in the same cycle.
  always_comb begin
    nextState  = state;
    capture    = 1'b0;
    writeSlot  = idxQ;
    effIdx     = idxQ;
    startFrame = 1'b0;
    incIdx     = 1'b0;
    clearIdx   = 1'b0;
    setErr     = 1'b0;
    errVal     = ERR_NONE;
    loadResult = 1'b0;
    clearTimer = 1'b0;
    runTick    = 1'b0;

    unique case (state)
      IDLE: begin
        if (progRise) begin
          capture    = 1'b1;
          writeSlot  = '0;
          startFrame = 1'b1;
          nextState  = LOAD;
        end
      end
      LOAD: begin
        if (progRise) begin
          if (idxQ < FULL_IDX) begin
            capture = 1'b1;
            incIdx  = 1'b1;
            effIdx  = idxQ + IDX_W'(1);
          end else begin
            setErr = 1'b1;
            errVal = ERR_OVERRUN;
          end
        end
        if (finRise) begin
          if (effIdx == FULL_IDX) begin
            nextState = START;
          end else begin
            setErr    = 1'b1;
            errVal    = ERR_SHORT;
            clearIdx  = 1'b1;
            nextState = IDLE;
          end
        end
      end
      START: begin
        clearTimer = 1'b1;
        nextState  = RUN;
      end
      RUN: begin
        runTick = 1'b1;
        if (progRise) begin
          setErr = 1'b1;
          errVal = ERR_OVERRUN;
        end
        if (iSNN_DONE) begin
          loadResult = 1'b1;
          clearIdx   = 1'b1;
          nextState  = IDLE;
        end else if (timerQ == TIMER_LAST) begin
          setErr    = 1'b1;
          errVal    = ERR_TIMEOUT;
          clearIdx  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Gating with iRESETn keeps the start pulse and busy flag quiet in a
  // reset cycle even before the state register has been cleared.
  assign oSNN_START = (state == START) && iRESETn;
  assign oBUSY      = (state != IDLE) && iRESETn;
  assign oCHUNK_IDX = idxQ;

  // Frame image, chunk index, result/error reporting and the run timer.
  // Unwritten slots deliberately keep the previous frame's contents.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      oIMAGE        <= '0;
      idxQ          <= '0;
      oRESULT       <= '0;
      oRESULT_VALID <= 1'b0;
      oERROR        <= ERR_NONE;
      timerQ        <= '0;
    end else begin
      if (capture) begin
        oIMAGE[int'(writeSlot) * CHUNK_W +: CHUNK_W] <= iDATA;
      end

      if (startFrame) begin
        idxQ <= IDX_W'(1);
      end else if (clearIdx) begin
        idxQ <= '0;
      end else if (incIdx) begin
        idxQ <= idxQ + IDX_W'(1);
      end

      if (startFrame) begin
        oERROR        <= ERR_NONE;
        oRESULT_VALID <= 1'b0;
      end else if (setErr) begin
        oERROR <= errVal;
      end

      if (loadResult) begin
        oRESULT       <= iSNN_RESULT;
        oRESULT_VALID <= 1'b1;
      end

      if (clearTimer) begin
        timerQ <= '0;
      end else if (runTick && (timerQ != TIMER_LAST)) begin
        timerQ <= timerQ + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Self-checking bench for snn_frame_sequencer. A behavioural frame model
// (slot array, chunk count and a few flags) is advanced on every clock edge
// from the raw inputs delayed by the synchroniser latency, and the DUT is
// compared against it every cycle. Directed frames are followed by
// randomized frames; literal expectations pin the model on the directed ones.
module tb_snn_frame_sequencer;

  localparam int CW  = 30;
  localparam int NC  = 27;
  localparam int RW  = 1;
  localparam int TO  = 64;
  localparam int IW  = CW * NC;

  logic          iCLK = 1'b0;
  logic          iRESETn = 1'b0;
  logic [CW-1:0] iDATA = '0;
  logic          iPROGRESS = 1'b0;
  logic          iFINISH = 1'b0;
  logic          iSNN_DONE = 1'b0;
  logic [RW-1:0] iSNN_RESULT = '0;
  logic [IW-1:0] oIMAGE;
  logic          oSNN_START;
  logic [RW-1:0] oRESULT;
  logic          oRESULT_VALID;
  logic          oBUSY;
  logic [4:0]    oCHUNK_IDX;
  logic [1:0]    oERROR;

  snn_frame_sequencer #(
    .CHUNK_W     (CW),
    .NUM_CHUNKS  (NC),
    .RESULT_W    (RW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .iCLK          (iCLK),
    .iRESETn       (iRESETn),
    .iDATA         (iDATA),
    .iPROGRESS     (iPROGRESS),
    .iFINISH       (iFINISH),
    .oIMAGE        (oIMAGE),
    .oSNN_START    (oSNN_START),
    .iSNN_DONE     (iSNN_DONE),
    .iSNN_RESULT   (iSNN_RESULT),
    .oRESULT       (oRESULT),
    .oRESULT_VALID (oRESULT_VALID),
    .oBUSY         (oBUSY),
    .oCHUNK_IDX    (oCHUNK_IDX),
    .oERROR        (oERROR)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;
  int startsSeen = 0;

  // Behavioural model: raw input histories (bit 0 newest), the frame slots
  // and a coarse description of where the frame is in its life.
  logic [3:0]    progHist = '0;
  logic [3:0]    finHist = '0;
  logic [CW-1:0] mSlot [NC];
  int            mCount = 0;
  bit            mOpen = 0;
  bit            mStartDue = 0;
  bit            mRunning = 0;
  int            mRunCycles = 0;
  logic [1:0]    mErr = '0;
  logic [RW-1:0] mRes = '0;
  bit            mValid = 0;

  // A level rise reaches the sequencer three edges after it is first sampled.
  always @(posedge iCLK) begin
    bit pe;
    bit fe;
    if (!iRESETn) begin
      progHist   = '0;
      finHist    = '0;
      for (int s = 0; s < NC; s++) mSlot[s] = '0;
      mCount     = 0;
      mOpen      = 0;
      mStartDue  = 0;
      mRunning   = 0;
      mRunCycles = 0;
      mErr       = '0;
      mRes       = '0;
      mValid     = 0;
    end else begin
      pe = progHist[2] & ~progHist[3];
      fe = finHist[2] & ~finHist[3];
      progHist = {progHist[2:0], iPROGRESS};
      finHist  = {finHist[2:0], iFINISH};
      if (mRunning) begin
        mRunCycles++;
        if (pe) mErr = 2'd2;
        if (iSNN_DONE) begin
          mRes     = iSNN_RESULT;
          mValid   = 1;
          mCount   = 0;
          mRunning = 0;
        end else if (mRunCycles == TO) begin
          mErr     = 2'd3;
          mCount   = 0;
          mRunning = 0;
        end
      end else if (mStartDue) begin
        mStartDue  = 0;
        mRunning   = 1;
        mRunCycles = 0;
      end else if (mOpen) begin
        if (pe) begin
          if (mCount < NC) begin
            mSlot[mCount] = iDATA;
            mCount++;
          end else begin
            mErr = 2'd2;
          end
        end
        if (fe) begin
          mOpen = 0;
          if (mCount == NC) begin
            mStartDue = 1;
          end else begin
            mErr   = 2'd1;
            mCount = 0;
          end
        end
      end else if (pe) begin
        mSlot[0] = iDATA;
        mCount   = 1;
        mValid   = 0;
        mErr     = 2'd0;
        mOpen    = 1;
      end
    end
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int bad;
    bad = -1;
    if (oSNN_START === 1'b1) startsSeen++;
    checkVal("start", oSNN_START, mStartDue);
    checkVal("busy", oBUSY, mOpen | mStartDue | mRunning);
    checkVal("chunkIdx", oCHUNK_IDX, mCount);
    checkVal("error", oERROR, mErr);
    checkVal("result", oRESULT, mRes);
    checkVal("resultValid", oRESULT_VALID, mValid);
    for (int s = 0; s < NC; s++) begin
      if (bad < 0 && oIMAGE[s*CW +: CW] !== mSlot[s]) bad = s;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("[TB] FAIL image slot %0d actual=%0h expected=%0h at %0t",
               bad, oIMAGE[bad*CW +: CW], mSlot[bad], $time);
    end
  endtask

  // Single compare process, sampling 1 time unit after each rising edge.
  always @(posedge iCLK) begin
    #1;
    checkOutput();
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [CW-1:0] data, input bit withFinish);
    iDATA     = data;
    iPROGRESS = 1'b1;
    iFINISH   = withFinish;
    tick(2);
    iPROGRESS = 1'b0;
    iFINISH   = 1'b0;
    tick(2);
  endtask

  task automatic sendFinish();
    iFINISH = 1'b1;
    tick(2);
    iFINISH = 1'b0;
    tick(2);
  endtask

  task automatic pulseDone(input logic [RW-1:0] res);
    iSNN_DONE   = 1'b1;
    iSNN_RESULT = res;
    tick(1);
    iSNN_DONE   = 1'b0;
  endtask

  task automatic waitStart(input int bound, output int lat);
    lat = 0;
    while (oSNN_START !== 1'b1 && lat < bound) begin
      tick(1);
      lat++;
    end
    if (lat >= bound) checkVal("startTimeout", oSNN_START, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int n;
    int s0;
    int nch;
    int dly;
    bit together;
    bit doReset;
    bit aborted;
    logic [CW-1:0] d0;
    logic [CW-1:0] d26;

    tick(3);
    checkVal("lit_resetImage", oIMAGE == '0, 1'b1);
    checkVal("lit_resetBusy", oBUSY, 1'b0);
    iRESETn = 1'b1;
    tick(2);

    // Reset held two cycles in the middle of loading.
    for (int k = 0; k < 10; k++) applyStimulus(CW'($urandom), 0);
    tick(2);
    checkVal("lit_midLoadIdx", oCHUNK_IDX, 5'd10);
    iRESETn = 1'b0;
    tick(2);
    checkVal("lit_rstImage", oIMAGE == '0, 1'b1);
    checkVal("lit_rstIdx", oCHUNK_IDX, 5'd0);
    checkVal("lit_rstBusy", oBUSY, 1'b0);
    iRESETn = 1'b1;
    d0 = CW'($urandom);
    applyStimulus(d0, 0);
    tick(1);
    checkVal("lit_slot0AfterRst", oIMAGE[CW-1:0], d0);
    checkVal("lit_idxAfterRst", oCHUNK_IDX, 5'd1);
    iRESETn = 1'b0;
    tick(1);
    iRESETn = 1'b1;
    tick(1);

    // Full frame with chunk k = k, then a result of 1 well inside the timeout.
    s0 = startsSeen;
    for (int k = 0; k < NC; k++) applyStimulus(CW'(k), 0);
    sendFinish();
    waitStart(10, lat);
    tick(40);
    pulseDone(1'b1);
    tick(3);
    checkVal("lit_img0", oIMAGE[0 +: CW], 30'd0);
    checkVal("lit_img13", oIMAGE[13*CW +: CW], 30'd13);
    checkVal("lit_img26", oIMAGE[26*CW +: CW], 30'd26);
    checkVal("lit_oneStart", startsSeen - s0, 1);
    checkVal("lit_result", oRESULT, 1'b1);
    checkVal("lit_valid", oRESULT_VALID, 1'b1);
    checkVal("lit_errNone", oERROR, 2'd0);

    // Short frame: 26 chunks then FINISH.
    s0 = startsSeen;
    for (int k = 0; k < 26; k++) applyStimulus(CW'($urandom), 0);
    sendFinish();
    tick(6);
    checkVal("lit_shortErr", oERROR, 2'd1);
    checkVal("lit_shortIdx", oCHUNK_IDX, 5'd0);
    checkVal("lit_shortBusy", oBUSY, 1'b0);
    checkVal("lit_shortNoStart", startsSeen - s0, 0);

    // Overrun: 28 chunks, the last one is dropped but the frame still starts.
    s0 = startsSeen;
    for (int k = 0; k < 28; k++) applyStimulus(CW'(100 + k), 0);
    sendFinish();
    waitStart(10, lat);
    tick(2);
    checkVal("lit_overrunErr", oERROR, 2'd2);
    checkVal("lit_overrunSlot26", oIMAGE[26*CW +: CW], 30'd126);
    checkVal("lit_overrunStart", startsSeen - s0, 1);
    pulseDone(1'b0);
    tick(3);

    // Chunk 27 and FINISH together, then a stray chunk while running.
    for (int k = 0; k < 26; k++) applyStimulus(CW'($urandom), 0);
    d26 = CW'($urandom);
    iDATA = d26;
    iPROGRESS = 1'b1;
    iFINISH = 1'b1;
    lat = 0;
    while (oSNN_START !== 1'b1 && lat < 12) begin
      tick(1);
      lat++;
      if (lat == 2) begin
        iPROGRESS = 1'b0;
        iFINISH = 1'b0;
      end
    end
    checkVal("lit_togetherLatency", lat, 4);
    applyStimulus(30'h3FFF_FFFF, 0);
    tick(2);
    checkVal("lit_runOverrunErr", oERROR, 2'd2);
    checkVal("lit_runSlot26", oIMAGE[26*CW +: CW], d26);
    pulseDone(1'b1);
    tick(3);

    // Timeout: START cycle, 64 run cycles, error visible after the next edge.
    for (int k = 0; k < NC; k++) applyStimulus(CW'($urandom), 0);
    sendFinish();
    waitStart(10, lat);
    n = 0;
    while (oERROR !== 2'd3 && n < 200) begin
      tick(1);
      n++;
    end
    checkVal("lit_timeoutCycles", n, 65);
    checkVal("lit_timeoutBusy", oBUSY, 1'b0);
    checkVal("lit_timeoutValid", oRESULT_VALID, 1'b0);
    tick(3);

    // Randomized frames checked purely against the model.
    for (int f = 0; f < 25; f++) begin
      nch = $urandom_range(25, 29);
      together = 1'($urandom_range(0, 1));
      doReset = ($urandom_range(0, 9) == 0);
      aborted = 0;
      for (int k = 0; k < nch - 1; k++) begin
        applyStimulus(CW'($urandom), 0);
        if (k == 3 && $urandom_range(0, 3) == 0) pulseDone(RW'($urandom));
        if (doReset && k == nch / 2) begin
          iRESETn = 1'b0;
          tick($urandom_range(1, 2));
          iRESETn = 1'b1;
          aborted = 1;
          break;
        end
      end
      if (aborted) begin
        tick(4);
        continue;
      end
      if (together) begin
        applyStimulus(CW'($urandom), 1);
      end else begin
        applyStimulus(CW'($urandom), 0);
        sendFinish();
      end
      if (nch >= NC) begin
        waitStart(10, lat);
        dly = $urandom_range(1, 90);
        if (dly >= 20 && $urandom_range(0, 1) == 1) begin
          applyStimulus(CW'($urandom), 0);
          tick(dly - 4);
        end else begin
          tick(dly);
        end
        if (oBUSY === 1'b1) pulseDone(RW'($urandom));
        tick(4);
      end else begin
        tick(4);
      end
    end

    tick(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
